cfu_quant_sched: RTL and testbench

//  Per-channel requantization scheduler in front of one cfu_quantizer instance.
//  - Holds a channel parameter table (bias, mul, shift) plus global offset/min/max.
//  - Accepts a valid/ready stream of {acc, channel}, sequences the quantizer's start/status handshake, streams out results.
//  - Sits between the conv accumulator drain and the CFU output/writeback path.

---
 rtl/cfu_quant_pkg.sv | 25 ++
 rtl/cfu_quant_sched.sv | 176 +++++++++++++++++
 tb/tb_cfu_quant_sched.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_quant_pkg.sv
// rtl/cfu_quant_pkg.sv - shared types and constants for the requantization scheduler
package cfu_quant_pkg;

    typedef struct packed {
        logic signed [31:0] bias;
        logic signed [31:0] mul;
        logic signed [5:0]  shift;
    } qparam_t;

    localparam logic [2:0] SEL_BIAS   = 3'd0;
    localparam logic [2:0] SEL_MUL    = 3'd1;
    localparam logic [2:0] SEL_SHIFT  = 3'd2;
    localparam logic [2:0] SEL_OFFSET = 3'd3;
    localparam logic [2:0] SEL_MIN    = 3'd4;
    localparam logic [2:0] SEL_MAX    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_WAIT,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/cfu_quant_sched.sv
// rtl/cfu_quant_sched.sv - per-channel requantization scheduler (QUANT_SCHED_PACK_EN packs int8 lanes)
module cfu_quant_sched
    import cfu_quant_pkg::*;
#(
    parameter  int NCH  = 16,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_sel,
    input  logic [CH_W-1:0] cfg_addr,
    input  logic [31:0]     cfg_wdata,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_acc,
    input  logic [CH_W-1:0] in_ch,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            out_last,
    output logic [31:0]     q_data_in,
    output logic [31:0]     q_bias,
    output logic [31:0]     q_mul,
    output logic [31:0]     q_offset,
    output logic [31:0]     q_min,
    output logic [31:0]     q_max,
    output logic [5:0]      q_shift,
    output logic            q_start,
    input  logic            q_status,
    input  logic [31:0]     q_data_out
);

    qparam_t            tbl [NCH];
    logic signed [31:0] g_offset;
    logic signed [31:0] g_min;
    logic signed [31:0] g_max;

    state_t      state;
    state_t      state_nxt;
    logic        q_last;
    logic [31:0] res;
    logic        accept;
    logic        slot_free;
    logic        emit_go;
    logic        load_out;
    logic        need_slot;
    logic [31:0] emit_word;

    assign in_ready  = (state == ST_IDLE);
    assign q_start   = (state == ST_ISSUE);
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign emit_go   = (state == ST_EMIT) && (!need_slot || slot_free);
    assign load_out  = (state == ST_EMIT) && need_slot && slot_free;

    // Channel table and global clamp/offset registers; writes land at the clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                tbl[i] <= '0;
            end
            g_offset <= '0;
            g_min    <= '0;
            g_max    <= '0;
        end else if (cfg_we) begin
            case (cfg_sel)
                SEL_BIAS:   tbl[cfg_addr].bias  <= cfg_wdata;
                SEL_MUL:    tbl[cfg_addr].mul   <= cfg_wdata;
                SEL_SHIFT:  tbl[cfg_addr].shift <= cfg_wdata[5:0];
                SEL_OFFSET: g_offset <= cfg_wdata;
                SEL_MIN:    g_min    <= cfg_wdata;
                SEL_MAX:    g_max    <= cfg_wdata;
                default:    ;
            endcase
        end
    end

    // Operand snapshot on accept; stays frozen until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data_in <= '0;
            q_bias    <= '0;
            q_mul     <= '0;
            q_shift   <= '0;
            q_offset  <= '0;
            q_min     <= '0;
            q_max     <= '0;
            q_last    <= 1'b0;
        end else if (accept) begin
            q_data_in <= in_acc;
            q_bias    <= tbl[in_ch].bias;
            q_mul     <= tbl[in_ch].mul;
            q_shift   <= tbl[in_ch].shift;
            q_offset  <= g_offset;
            q_min     <= g_min;
            q_max     <= g_max;
            q_last    <= in_last;
        end
    end

    // Capture the quantizer result once it reports done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else if ((state == ST_WAIT) && q_status) begin
            res <= q_data_out;
        end
    end

`ifdef QUANT_SCHED_PACK_EN
    logic [31:0] pack_buf;
    logic [1:0]  lane_cnt;

    assign need_slot = q_last || (lane_cnt == 2'd3);
    assign emit_word = pack_buf | ({24'd0, res[7:0]} << {lane_cnt, 3'b000});

    // Lane accumulator: a word leaves on the fourth lane or on the tile's last element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_buf <= '0;
            lane_cnt <= '0;
        end else if (emit_go) begin
            if (need_slot) begin
                pack_buf <= '0;
                lane_cnt <= '0;
            end else begin
                pack_buf <= emit_word;
                lane_cnt <= lane_cnt + 2'd1;
            end
        end
    end
`else
    assign need_slot = 1'b1;
    assign emit_word = res;
`endif

    // Single-entry output register; held until downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= emit_word;
            out_last  <= q_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; ARM skips the cycle where a stale done level may still be high
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_ARM;
            ST_ARM:   state_nxt = ST_WAIT;
            ST_WAIT:  if (q_status) state_nxt = ST_EMIT;
            ST_EMIT:  if (emit_go) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cfu_quant_sched.sv
// tb/tb_cfu_quant_sched.sv - scoreboard bench for cfu_quant_sched with a behavioural quantizer
module tb_cfu_quant_sched;

    localparam int NCH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_sel = '0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_acc = '0;
    logic [3:0]  in_ch = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic [31:0] q_data_in, q_bias, q_mul, q_offset, q_min, q_max;
    logic [5:0]  q_shift;
    logic        q_start;
    logic        q_status = 1'b0;
    logic [31:0] q_data_out = '0;

    cfu_quant_sched #(.NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_ch(in_ch), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .q_data_in(q_data_in), .q_bias(q_bias), .q_mul(q_mul), .q_offset(q_offset),
        .q_min(q_min), .q_max(q_max), .q_shift(q_shift), .q_start(q_start),
        .q_status(q_status), .q_data_out(q_data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;
    exp_t sb[$];

    // shadow of the configuration as the reference model sees it
    logic signed [31:0] sh_bias [NCH];
    logic signed [31:0] sh_mul [NCH];
    logic signed [5:0]  sh_shift [NCH];
    logic signed [31:0] sh_off, sh_min, sh_max;
    logic [31:0]        pk_word;
    int                 pk_n;

    bit hold_ready = 1'b0;
    int qdelay_fix = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // rounding-doubling high multiply, rounding right shift, offset, clamp
    function automatic logic signed [31:0] requant(input logic signed [31:0] acc, input logic signed [31:0] bias,
                                                   input logic signed [31:0] mul, input logic signed [5:0] sh,
                                                   input logic signed [31:0] off, input logic signed [31:0] mn,
                                                   input logic signed [31:0] mx);
        longint x, ab, nudge, r, mask, rem, thr;
        int e;
        x = longint'(acc) + longint'(bias);
        if (sh > 0) x = x <<< int'(sh);
        ab = x * longint'(mul);
        nudge = (ab >= 0) ? (64'sd1 <<< 30) : (64'sd1 - (64'sd1 <<< 30));
        r = (ab + nudge) / (64'sd1 <<< 31);
        if (sh < 0) begin
            e    = -int'(sh);
            mask = (64'sd1 <<< e) - 1;
            rem  = r & mask;
            thr  = (mask >>> 1) + ((r < 0) ? 1 : 0);
            r    = (r >>> e) + ((rem > thr) ? 1 : 0);
        end
        r = r + longint'(off);
        if (r < longint'(mn)) r = longint'(mn);
        if (r > longint'(mx)) r = longint'(mx);
        return 32'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            sh_bias[i] = 0; sh_mul[i] = 0; sh_shift[i] = 0;
        end
        sh_off = 0; sh_min = 0; sh_max = 0;
        pk_word = 0; pk_n = 0;
        sb.delete();
    endtask

    task automatic model_cfg(input logic [2:0] sel, input int addr, input logic [31:0] data);
        case (sel)
            3'd0: sh_bias[addr] = data;
            3'd1: sh_mul[addr] = data;
            3'd2: sh_shift[addr] = data[5:0];
            3'd3: sh_off = data;
            3'd4: sh_min = data;
            3'd5: sh_max = data;
            default: ;
        endcase
    endtask

    task automatic model_accept(input logic signed [31:0] acc, input int ch, input logic last,
                                input bit use_lit, input logic signed [31:0] lit);
        logic signed [31:0] r;
        exp_t e;
        r = use_lit ? lit : requant(acc, sh_bias[ch], sh_mul[ch], sh_shift[ch], sh_off, sh_min, sh_max);
`ifdef QUANT_SCHED_PACK_EN
        pk_word[8*pk_n +: 8] = r[7:0];
        pk_n++;
        if (pk_n == 4 || last) begin
            e.data = pk_word; e.last = last;
            sb.push_back(e);
            pk_word = 0; pk_n = 0;
        end
`else
        e.data = r; e.last = last;
        sb.push_back(e);
`endif
    endtask

    task automatic cfg_write(input logic [2:0] sel, input int addr, input logic [31:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(addr); cfg_wdata = data;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        model_cfg(sel, addr, data);
    endtask

    // issues one element; optionally a cfg write lands in the very accept cycle
    task automatic send(input logic signed [31:0] acc, input int ch, input logic last,
                        input bit use_lit, input logic signed [31:0] lit,
                        input bit with_cfg, input logic [2:0] sel, input int addr, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1; in_acc = acc; in_ch = 4'(ch); in_last = last;
        if (with_cfg) begin
            cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(addr); cfg_wdata = data;
        end
        @(posedge clk);
        #1 in_valid = 1'b0; cfg_we = 1'b0;
        model_accept(acc, ch, last, use_lit, lit);
        if (with_cfg) model_cfg(sel, addr, data);
    endtask

    task automatic send_plain(input logic signed [31:0] acc, input int ch, input logic last,
                              input bit use_lit, input logic signed [31:0] lit);
        send(acc, ch, last, use_lit, lit, 1'b0, 3'd0, 0, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic cfg_ch(input int ch, input int b, input int m, input int s);
        cfg_write(3'd0, ch, b);
        cfg_write(3'd1, ch, m);
        cfg_write(3'd2, ch, s);
    endtask

    // behavioural quantizer: done level rises a few cycles after start, drops on the next start
    int  qcnt = 0;
    bit  qpend = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_status <= 1'b0; qpend <= 1'b0; qcnt <= 0; q_data_out <= '0;
        end else if (q_start) begin
            q_status   <= 1'b0;
            qpend      <= 1'b1;
            qcnt       <= (qdelay_fix >= 0) ? qdelay_fix : int'($urandom_range(0, 4));
            q_data_out <= requant(q_data_in, q_bias, q_mul, q_shift, q_offset, q_min, q_max);
        end else if (qpend) begin
            if (qcnt == 0) begin
                q_status <= 1'b1; qpend <= 1'b0;
            end else begin
                qcnt <= qcnt - 1;
            end
        end
    end

    // monitor: drives out_ready and compares every presented word against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", out_data, 32'hxxxxxxxx);
                end else begin
                    check("out_data", out_data, sb[0].data);
                    check("out_last", {31'd0, out_last}, {31'd0, sb[0].last});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q_start", {31'd0, q_start}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_q_bias", q_bias, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors
        cfg_write(3'd3, 0, -128);
        cfg_write(3'd4, 0, -128);
        cfg_write(3'd5, 0, 127);
        cfg_ch(3, 18377, 1459272781, -8);
        cfg_ch(5, -13074, 1201775990, -9);
        cfg_ch(6, 18642, 2061439064, -9);
        send_plain(-16113, 3, 1'b1, 1'b1, -122);
        send_plain(-17704, 5, 1'b1, 1'b1, -128);
        send_plain(8918, 6, 1'b1, 1'b1, -76);
        drain();

        // three back to back, tile ends on the third
        send_plain(-16113, 3, 1'b0, 1'b1, -122);
        send_plain(-17704, 5, 1'b0, 1'b1, -128);
        send_plain(8918, 6, 1'b1, 1'b1, -76);
        drain();

        // output back-pressure: second result parks in EMIT, no new accept or start
        hold_ready = 1'b1;
        send_plain(-16113, 3, 1'b1, 1'b1, -122);
        send_plain(8918, 6, 1'b1, 1'b1, -76);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_q_start", {31'd0, q_start}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        hold_ready = 1'b0;
        drain();

        // bias rewrite in the accept cycle takes effect only for the next element
        send(-16113, 3, 1'b1, 1'b1, -122, 1'b1, 3'd0, 3, 32'd5000);
        send_plain(-16113, 3, 1'b1, 1'b0, 0);
        drain();

        // reset while waiting on the quantizer
        qdelay_fix = 12;
        send_plain(-16113, 3, 1'b1, 1'b1, -122);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_q_start", {31'd0, q_start}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        model_reset();
        qdelay_fix = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cfg_write(3'd3, 0, -128);
        cfg_write(3'd4, 0, -128);
        cfg_write(3'd5, 0, 127);
        cfg_ch(3, 18377, 1459272781, -8);
        send_plain(-16113, 3, 1'b1, 1'b1, -122);
        drain();

        // randomized traffic against the reference model
        cfg_write(3'd3, 0, int'($urandom_range(0, 40)) - 20);
        for (int c = 0; c < NCH; c++) begin
            cfg_ch(c, int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(32'h4000_0000, 32'h7FFF_FFFF)),
                   int'($urandom_range(0, 12)) - 10);
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_write(3'd0, int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 65535)) - 32768);
            end
            send_plain(int'($urandom_range(0, 2097152)) - 1048576, int'($urandom_range(0, NCH - 1)),
                       ($urandom_range(0, 4) == 0) || (i == 59), 1'b0, 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
